// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg: shared pipeline constants for hazard control and the MDU timer
package pipeline_hazard_ctrl_pkg;
    localparam int MULT_CYCLES_DEF = 4;
    localparam int DIV_CYCLES_DEF  = 32;
    localparam logic MD_IDLE = 1'b0;
    localparam logic MD_BUSY = 1'b1;
    localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/pipeline_hazard_ctrl_md_busy_timer.sv
// pipeline_hazard_ctrl_md_busy_timer: MDU busy countdown with a one-cycle done pulse
module pipeline_hazard_ctrl_md_busy_timer
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = 6
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic start_i,
    input  logic is_div_i,
    output logic busy_o,
    output logic done_o
);
    logic             state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    // Starts are only accepted in IDLE; BUSY counts down and leaves on the last count
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (state_q == MD_IDLE) begin
            if (start_i) begin
                state_d = MD_BUSY;
                cnt_d   = is_div_i ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            end
        end else begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                state_d = MD_IDLE;
                done_d  = 1'b1;
            end
        end
    end

    // Reset abandons any running operation without a done pulse
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign busy_o = (state_q == MD_BUSY);
    assign done_o = done_q;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush control for load-use, MEM redirects and the multi-cycle MDU
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = 6
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [4:0]  id_rs_i,
    input  logic [4:0]  id_rt_i,
    input  logic        id_uses_rt_i,
    input  logic        id_reads_hilo_i,
    input  logic        id_is_md_i,
    input  logic        ex_mem_read_i,
    input  logic [4:0]  ex_rw_i,
    input  logic        ex_md_start_i,
    input  logic        ex_md_is_div_i,
    input  logic        mem_redirect_i,
    output logic        pc_write_o,
    output logic        ifid_stall_o,
    output logic        ifid_flush_o,
    output logic        idex_bubble_o,
    output logic        exmem_bubble_o,
    output logic        md_busy_o,
    output logic        md_done_o,
    output logic [31:0] stall_count_o
);
    logic        load_use, md_hazard, stall;
    logic [31:0] stall_count_q, stall_count_d;

    // A redirect squashes the younger mult/div, so it never starts the timer
    pipeline_hazard_ctrl_md_busy_timer #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) u_md_busy_timer (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .start_i (ex_md_start_i & ~mem_redirect_i),
        .is_div_i(ex_md_is_div_i),
        .busy_o  (md_busy_o),
        .done_o  (md_done_o)
    );

    // Hazard detection and priority: redirect overrides any stall it would squash
    always_comb begin
        load_use       = ex_mem_read_i && ex_rw_i != REG_ZERO &&
                         (ex_rw_i == id_rs_i || (id_uses_rt_i && ex_rw_i == id_rt_i));
        md_hazard      = md_busy_o & (id_reads_hilo_i | id_is_md_i);
        stall          = load_use | md_hazard;
        pc_write_o     = mem_redirect_i | ~stall;
        ifid_stall_o   = ~mem_redirect_i & stall;
        ifid_flush_o   = mem_redirect_i;
        idex_bubble_o  = mem_redirect_i | stall;
        exmem_bubble_o = mem_redirect_i;
        stall_count_d  = (!pc_write_o && stall_count_q != '1) ? stall_count_q + 32'd1 : stall_count_q;
    end

    // Saturating count of cycles in which the PC was held
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) stall_count_q <= '0;
        else          stall_count_q <= stall_count_d;
    end

    assign stall_count_o = stall_count_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed vectors for the hazard controller
module tb_pipeline_hazard_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  id_rs, id_rt, ex_rw;
    logic        id_uses_rt, id_reads_hilo, id_is_md, ex_mem_read, ex_md_start, ex_md_is_div, mem_redirect;
    logic        pc_write, ifid_stall, ifid_flush, idex_bubble, exmem_bubble, md_busy, md_done;
    logic [31:0] stall_count;
    int          n_vec = 0;
    int          n_err = 0;
    int          busy_n, done_n;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .id_rs_i        (id_rs),
        .id_rt_i        (id_rt),
        .id_uses_rt_i   (id_uses_rt),
        .id_reads_hilo_i(id_reads_hilo),
        .id_is_md_i     (id_is_md),
        .ex_mem_read_i  (ex_mem_read),
        .ex_rw_i        (ex_rw),
        .ex_md_start_i  (ex_md_start),
        .ex_md_is_div_i (ex_md_is_div),
        .mem_redirect_i (mem_redirect),
        .pc_write_o     (pc_write),
        .ifid_stall_o   (ifid_stall),
        .ifid_flush_o   (ifid_flush),
        .idex_bubble_o  (idex_bubble),
        .exmem_bubble_o (exmem_bubble),
        .md_busy_o      (md_busy),
        .md_done_o      (md_done),
        .stall_count_o  (stall_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        id_rs = 5'd0; id_rt = 5'd0; ex_rw = 5'd0;
        id_uses_rt = 1'b0; id_reads_hilo = 1'b0; id_is_md = 1'b0;
        ex_mem_read = 1'b0; ex_md_start = 1'b0; ex_md_is_div = 1'b0; mem_redirect = 1'b0;
    endtask

    task automatic chk_ctrl(input string tag, input logic [4:0] exp);
        chk(tag, {pc_write, ifid_stall, ifid_flush, idex_bubble, exmem_bubble}, {27'd0, exp});
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        #3;
        chk("reset_busy", md_busy, 0);
        chk("reset_done", md_done, 0);
        chk("reset_count", stall_count, 0);
        chk_ctrl("reset_ctrl", 5'b10000);
        @(negedge clk); rst_n = 1'b1;

        // load-use on rs: one-cycle stall
        @(negedge clk);
        ex_mem_read = 1'b1; ex_rw = 5'd8; id_rs = 5'd8;
        #1 chk_ctrl("load_use_rs", 5'b01010);
        @(negedge clk);
        ex_mem_read = 1'b0;
        #1 chk_ctrl("load_use_release", 5'b10000);
        chk("load_use_count", stall_count, 1);

        // register zero never hazards
        ex_mem_read = 1'b1; ex_rw = 5'd0; id_rs = 5'd0;
        #1 chk_ctrl("reg_zero", 5'b10000);
        // rt only matters when it is actually read
        ex_rw = 5'd9; id_rs = 5'd3; id_rt = 5'd9; id_uses_rt = 1'b0;
        #1 chk_ctrl("rt_unused", 5'b10000);
        id_uses_rt = 1'b1;
        #1 chk_ctrl("rt_used", 5'b01010);
        @(negedge clk);
        clear_inputs();
        #1 chk("rt_count", stall_count, 2);

        // mult then mfhi: 4 stall cycles, released on done
        @(negedge clk);
        ex_md_start = 1'b1;
        #1 chk("mult_start_busy", md_busy, 0);
        @(negedge clk);
        ex_md_start = 1'b0; id_reads_hilo = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            #1 chk($sformatf("mult_busy_%0d", i), md_busy, 1);
            chk_ctrl($sformatf("mfhi_stall_%0d", i), 5'b01010);
            @(negedge clk);
        end
        #1 chk("mult_done", md_done, 1);
        chk("mult_busy_clear", md_busy, 0);
        chk_ctrl("mfhi_release", 5'b10000);
        chk("mult_count", stall_count, 6);
        @(negedge clk);
        id_reads_hilo = 1'b0;
        #1 chk("mult_done_pulse", md_done, 0);

        // divide: 32 busy cycles and exactly one done
        @(negedge clk);
        ex_md_start = 1'b1; ex_md_is_div = 1'b1;
        @(negedge clk);
        ex_md_start = 1'b0; ex_md_is_div = 1'b0;
        busy_n = 0; done_n = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            busy_n += int'(md_busy);
            done_n += int'(md_done);
            @(negedge clk);
        end
        chk("div_busy_cycles", busy_n, 32);
        chk("div_done_pulses", done_n, 1);

        // redirect wins over load-use and does not count as a stall
        ex_mem_read = 1'b1; ex_rw = 5'd8; id_rs = 5'd8; mem_redirect = 1'b1;
        #1 chk_ctrl("redirect_over_stall", 5'b10111);
        @(negedge clk);
        clear_inputs();
        #1 chk("redirect_count", stall_count, 6);

        // start squashed by a redirect never goes busy
        ex_md_start = 1'b1; mem_redirect = 1'b1;
        @(negedge clk);
        clear_inputs();
        busy_n = 0;
        for (int i = 0; i < 3; i++) begin
            #1 busy_n += int'(md_busy);
            @(negedge clk);
        end
        chk("squashed_start_busy", busy_n, 0);

        // reset while cnt=2 abandons the op with no done pulse
        ex_md_start = 1'b1;
        @(negedge clk);
        ex_md_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 chk("pre_reset_busy", md_busy, 1);
        rst_n = 1'b0;
        #1 chk("reset_mid_busy", md_busy, 0);
        chk("reset_mid_count", stall_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        done_n = 0;
        for (int i = 0; i < 8; i++) begin
            #1 done_n += int'(md_done);
            @(negedge clk);
        end
        chk("reset_no_done", done_n, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
